// File: rtl/bus_bridge_if.sv
// rtl/bus_bridge_if.sv - byte-stream and strobe/ack/retry bus signals of the bus_bridge initiator
interface bus_bridge_if #(
    parameter int ADDR_BITS = 28
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          data_out;
    logic [31:0]          data_in;
    logic [3:0]           select;
    logic                 write;
    logic                 strobe;
    logic                 ack;
    logic                 retry;
    logic                 busy;

    modport master (
        input  in_data, in_valid, out_ready, data_in, ack, retry,
        output in_ready, out_data, out_valid, addr, data_out, select, write, strobe, busy
    );

    modport slave (
        output in_data, in_valid, out_ready, data_in, ack, retry,
        input  in_ready, out_data, out_valid, addr, data_out, select, write, strobe, busy
    );
endinterface

// File: rtl/bus_bridge.sv
// rtl/bus_bridge.sv - command-byte to bus-transaction initiator for host peek/poke access
module bus_bridge #(
    parameter int ADDR_BITS = 28,
    parameter int WORD_BITS = 32,
    parameter int TIMEOUT   = 1023
) (
    input  logic           clock,
    input  logic           reset_n,
    bus_bridge_if.master   bus
);
    localparam int               CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]    TMO_MAX    = '1;
    localparam logic [7:0]       OP_WRITE   = 8'h57;
    localparam logic [7:0]       OP_READ    = 8'h52;
    localparam logic [7:0]       ST_OK      = 8'h06;
    localparam logic [7:0]       ST_TIMEOUT = 8'h15;
    localparam logic [7:0]       ST_BAD     = 8'h3F;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, WAIT, RESP, RDATA} state_t;

    state_t                state, state_nx;
    logic                  is_write;
    logic [1:0]            cnt;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [WORD_BITS-1:0]  wdata_q;
    logic [WORD_BITS-1:0]  rdata_q;
    logic [7:0]            status_q;
    logic [CW-1:0]         tmo_q;
    logic                  in_hs;
    logic                  out_hs;
    logic                  timed_out;

    assign in_hs     = bus.in_valid && bus.in_ready;
    assign out_hs    = bus.out_valid && bus.out_ready;
    assign timed_out = (tmo_q >= CW'(TIMEOUT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // ack beats timeout, timeout beats retry
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (in_hs) state_nx = (bus.in_data == OP_WRITE || bus.in_data == OP_READ) ? ADDR : RESP;
            ADDR:  if (in_hs && cnt == 2'd3) state_nx = is_write ? DATA : ISSUE;
            DATA:  if (in_hs && cnt == 2'd3) state_nx = ISSUE;
            ISSUE: begin
                if (bus.ack)        state_nx = RESP;
                else if (bus.retry) state_nx = ISSUE;
                else                state_nx = WAIT;
            end
            WAIT: begin
                if (bus.ack)        state_nx = RESP;
                else if (timed_out) state_nx = RESP;
                else if (bus.retry) state_nx = ISSUE;
            end
            RESP:  if (out_hs) state_nx = (status_q == ST_OK && !is_write) ? RDATA : IDLE;
            RDATA: if (out_hs && cnt == 2'd3) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            is_write <= 1'b0;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= '0;
            tmo_q    <= '0;
        end else begin
            case (state)
                IDLE: if (in_hs) begin
                    is_write <= (bus.in_data == OP_WRITE);
                    status_q <= ST_BAD;
                    cnt      <= '0;
                end
                ADDR: if (in_hs) begin
                    addr_q <= {addr_q[ADDR_BITS-9:0], bus.in_data};
                    cnt    <= cnt + 2'd1;
                    tmo_q  <= '0;
                end
                DATA: if (in_hs) begin
                    wdata_q <= {wdata_q[WORD_BITS-9:0], bus.in_data};
                    cnt     <= cnt + 2'd1;
                    tmo_q   <= '0;
                end
                ISSUE, WAIT: begin
                    // retries keep counting against the same budget
                    if (tmo_q != TMO_MAX) tmo_q <= tmo_q + CW'(1);
                    cnt <= '0;
                    if (bus.ack) begin
                        status_q <= ST_OK;
                        if (!is_write) rdata_q <= bus.data_in;
                    end else if (state == WAIT && timed_out) begin
                        status_q <= ST_TIMEOUT;
                    end
                end
                RDATA: if (out_hs) begin
                    rdata_q <= rdata_q << 8;
                    cnt     <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) || (state == ADDR) || (state == DATA);
    assign bus.strobe    = (state == ISSUE);
    assign bus.select    = (state == ISSUE || state == WAIT) ? 4'b1111 : 4'b0000;
    assign bus.write     = is_write && (state == ISSUE || state == WAIT);
    assign bus.addr      = {addr_q[ADDR_BITS-1:2], 2'b00};
    assign bus.data_out  = wdata_q;
    assign bus.out_valid = (state == RESP) || (state == RDATA);
    assign bus.out_data  = (state == RESP)  ? status_q :
                           (state == RDATA) ? rdata_q[WORD_BITS-1 -: 8] : 8'h00;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_bus_bridge.sv
// tb/tb_bus_bridge.sv - directed and randomized checks of bus_bridge against a memory-level model
module tb_bus_bridge;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    bus_bridge_if #(.ADDR_BITS(28)) bus ();

    bus_bridge #(.ADDR_BITS(28), .WORD_BITS(32), .TIMEOUT(15)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int          passed = 0;
    int          total  = 0;
    int          dly [3];
    bit          ack_with_retry = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] ram     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic bus_phase(input int nret, input logic [31:0] ea, input bit ew,
                             input logic [31:0] ewd, output int nstb);
        int cd = -1;
        int ri = 0;
        bit done = 0;
        int budget = 0;
        nstb = 0;
        check("strobe_latency", bus.strobe, 1);
        while (!done && budget < 60) begin
            bus.ack   = 1'b0;
            bus.retry = 1'b0;
            if (bus.strobe === 1'b1) begin
                nstb++;
                check("addr", bus.addr, ea);
                check("write", bus.write, ew);
                check("select", bus.select, 4'hF);
                if (ew) check("data_out", bus.data_out, ewd);
                cd = dly[ri];
            end
            if (cd == 0) begin
                if (ri < nret) begin
                    bus.retry = 1'b1;
                end else begin
                    bus.ack     = 1'b1;
                    bus.retry   = ack_with_retry;
                    bus.data_in = ram.exists(ea) ? ram[ea] : 32'h0;
                    if (ew) ram[ea] = bus.data_out;
                    done = 1;
                end
                ri++;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            @(negedge clock);
            budget++;
        end
        bus.ack   = 1'b0;
        bus.retry = 1'b0;
        check("bus_done", done, 1);
        check("resp_latency", bus.out_valid, 1);
        check("select_drop", bus.select, 4'h0);
    endtask

    task automatic recv(input int stall0);
        int n;
        for (int i = 0; i < exp_q.size(); i++) begin
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 50) begin
                @(negedge clock);
                n++;
            end
            check("out_valid_wait", bus.out_valid, 1);
            repeat ((i == 0) ? stall0 : int'($urandom_range(0, 1))) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, exp_q[i]);
                check("hold_in_ready", bus.in_ready, 0);
                @(negedge clock);
            end
            check("out_data", bus.out_data, exp_q[i]);
            bus.out_ready = 1'b1;
            @(negedge clock);
            bus.out_ready = 1'b0;
        end
        check("idle_busy", bus.busy, 0);
        check("idle_valid", bus.out_valid, 0);
        check("idle_in_ready", bus.in_ready, 1);
    endtask

    // Reference: a word-addressed memory; response bytes follow the command format.
    task automatic do_txn(input bit w, input logic [31:0] raw, input logic [31:0] wd,
                          input int nret, input int stall0);
        logic [31:0] ea;
        logic [31:0] rd;
        int nstb;
        ea = raw & 32'h0FFF_FFFC;
        send_byte(w ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) send_byte(raw[8*i +: 8]);
        if (w) for (int i = 3; i >= 0; i--) send_byte(wd[8*i +: 8]);
        bus_phase(nret, ea, w, wd, nstb);
        check("strobe_count", nstb, nret + 1);
        exp_q.delete();
        exp_q.push_back(8'h06);
        if (w) begin
            ref_mem[ea] = wd;
        end else begin
            rd = ref_mem.exists(ea) ? ref_mem[ea] : 32'h0;
            for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
        end
        recv(stall0);
    endtask

    initial begin
        int k;
        int nstb;
        logic [31:0] raw;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = 32'h0;
        bus.ack       = 1'b0;
        bus.retry     = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_strobe", bus.strobe, 0);
        check("rst_write", bus.write, 0);
        check("rst_select", bus.select, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        reset_n = 1'b1;
        @(negedge clock);

        // directed write, ack two cycles after strobe
        dly = '{2, 0, 0};
        do_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0);

        // read with two retries
        ram[32'h0800_0004]     = 32'h1234_5678;
        ref_mem[32'h0800_0004] = 32'h1234_5678;
        dly = '{1, 0, 2};
        do_txn(1'b0, 32'h0800_0004, 32'h0, 2, 1);

        // unknown opcode under backpressure
        send_byte(8'h41);
        check("bad_busy", bus.busy, 1);
        check("bad_in_ready", bus.in_ready, 0);
        exp_q.delete();
        exp_q.push_back(8'h3F);
        recv(10);

        // timeout with a late stray ack
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
        check("to_strobe", bus.strobe, 1);
        k = 0;
        nstb = 0;
        while (bus.out_valid !== 1'b1 && k < 40) begin
            if (bus.strobe === 1'b1) nstb++;
            @(negedge clock);
            k++;
        end
        check("to_latency", k, 16);
        check("to_status", bus.out_data, 8'h15);
        check("to_strobes", nstb, 1);
        repeat (2) @(negedge clock);
        bus.ack     = 1'b1;
        bus.data_in = 32'hAAAA_5555;
        @(negedge clock);
        bus.ack     = 1'b0;
        check("to_stray_data", bus.out_data, 8'h15);
        check("to_stray_valid", bus.out_valid, 1);
        check("to_stray_strobe", bus.strobe, 0);
        exp_q.delete();
        exp_q.push_back(8'h15);
        recv(0);

        // address masking, ack in the strobe cycle
        dly = '{0, 0, 0};
        do_txn(1'b0, 32'hFFFF_FFFF, 32'h0, 0, 0);

        // reset in the middle of a read command
        send_byte(8'h52); send_byte(8'h08); send_byte(8'h00);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_strobe", bus.strobe, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst_no_strobe", bus.strobe, 0);
        ram[32'h0000_0040]     = 32'hCAFE_F00D;
        ref_mem[32'h0000_0040] = 32'hCAFE_F00D;
        dly = '{1, 0, 0};
        do_txn(1'b0, 32'h0000_0040, 32'h0, 0, 0);

        // randomized writes/reads over a small address window
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 3; i++) dly[i] = $urandom_range(0, 3);
            ack_with_retry = 1'($urandom_range(0, 1));
            raw = ($urandom() & 32'hF000_0003) | (32'h0000_1000 + 32'($urandom_range(0, 3)) * 32'h10);
            do_txn(1'($urandom_range(0, 1)), raw, $urandom(), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        ack_with_retry = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bus_bridge.md
Name: bus_bridge

Overview:
- Byte-stream-to-bus initiator; the initiator end of the SoC data bus, peer of the CPU data port.
- Takes command bytes from a UART receive stream.
- Issues word reads/writes on the strobe/ack/retry bus and returns status and read data as a byte stream.
- Serves as the host-side debug/loader path: peek/poke RAM, UART and video space without firmware help.

Parameters:
ADDR_BITS, 28, bus byte-address width.
WORD_BITS, 32, bus data width; fixed at 32 for this command format.
TIMEOUT, 1023, cycles allowed per transaction from first strobe to ack, retries included.

Ports:
clock  in  1  bus clock
reset_n  in  1  asynchronous active-low reset
in_data  in  8  command byte
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted when in_valid && in_ready
out_data  out  8  response byte
out_valid  out  1  out_data valid; held until accepted
out_ready  in  1  sink accepts when out_valid && out_ready
addr  out  ADDR_BITS  bus byte address, bits [1:0] always 0
data_out  out  32  write data to responder
data_in  in  32  read data from responder, valid on ack
select  out  4  byte lanes; 'b1111 during a transaction, 0 otherwise
write  out  1  1 = write transaction
strobe  out  1  one-cycle request pulse
ack  in  1  responder completed; data_in valid this cycle
retry  in  1  responder refused; re-issue
busy  out  1  high in any state but IDLE

Behaviour:
- Reset (async, reset_n low): state IDLE; all of the following hold until the next accepted byte:
  - strobe=0, write=0, select=0, addr=0, data_out=0
  - out_valid=0, out_data=0, busy=0, in_ready=1
- Command format (multi-byte fields big-endian):
  - Write: 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0.
  - Read: 0x52 'R', A3 A2 A1 A0.
  - Address bits above ADDR_BITS are discarded; addr[1:0] forced to 0.
- Responses:
  - Write ok: 0x06.
  - Read ok: 0x06 D3 D2 D1 D0.
  - Timeout: 0x15, no data bytes.
  - Unknown opcode: 0x3F; return to IDLE.
- States:
  - IDLE: accept opcode. 'W'/'R' -> ADDR with byte count 0; else -> RESP with 0x3F.
  - ADDR: shift in 4 bytes. After the 4th: 'W' -> DATA, 'R' -> ISSUE.
  - DATA: shift in 4 bytes; after the 4th -> ISSUE.
  - ISSUE: assert strobe for exactly 1 cycle with addr/write/data_out/select stable; -> WAIT.
  - WAIT: hold addr/write/data_out/select.
    - ack -> capture data_in (reads), go to RESP with 0x06.
    - retry -> ISSUE on the next cycle.
    - timeout counter reaches TIMEOUT -> RESP with 0x15; a later stray ack is ignored.
  - RESP: out_valid=1 with the status byte; advance on handshake. Reads after 0x06 -> RDATA; otherwise -> IDLE.
  - RDATA: emit D3..D0, one per handshake; -> IDLE after D0.
- in_ready=1 only in IDLE, ADDR, DATA. Bytes are never accepted during ISSUE/WAIT/RESP/RDATA.
- Latency:
  - Last command byte accepted in cycle N -> strobe high in cycle N+1.
  - ack in cycle M -> out_valid high in cycle M+1.
- ack and retry asserted together: ack wins.
- ack in the same cycle as strobe is legal and completes the transaction.
- Timeout counter clears on entry to ISSUE from ADDR/DATA only; retry re-issues do not clear it. Counter width is ceil(log2(TIMEOUT+1)) and it saturates.
- select and write drop to 0 on leaving WAIT.
- out_data/out_valid change only after a handshake (no change while out_valid && !out_ready).
- Reset mid-transaction: immediate return to reset values; any partial command is discarded; strobe is never left high.
- busy=1 from the cycle after the opcode is accepted until the final response byte is accepted.

Test Plan:
- Write: send 57 00 00 01 00 DE AD BE EF, ack 2 cycles after strobe -> one strobe, addr=0x0000100, write=1, select='b1111, data_out=0xDEADBEEF; response 06.
- Read with retry: send 52 08 00 00 04; responder retries twice then acks with data_in=0x12345678 -> strobe count 3, addr=0x8000004, write=0; response 06 12 34 56 78.
- Timeout: TIMEOUT=15, read with no ack/retry -> status 15 at cycle 16 after strobe, no data bytes; ack injected 3 cycles later is ignored; busy returns to 0.
- Backpressure and bad opcode: send 41 with out_ready held low for 10 cycles -> out_data stays 3F, out_valid stays 1; in_ready=0 until accepted.
- Address masking: read with address bytes FF FF FF FF -> addr=0xFFFFFFC.
- Reset mid-command: reset_n low after 3 of 5 read bytes, then a full valid read -> only the second command produces a strobe and response.
